ele_ctrl_n: RTL and testbench
=============================

Name: ele_ctrl_n

Overview:
- Parametrised multi-floor successor to the two-floor elevator controller.
- Takes per-floor call buttons and keeps one pending request per floor.
- Schedules car movement with a directional (SCAN) policy, runs timed travel and door phases, and drives floor, state, countdown, LED and beeper outputs for the display/board top level.
- Everything is synchronous to one clock. Buttons are rising-edge detected in-clock; no button signal is used as a clock.

Parameters:
- N_FLOORS, 4: number of floors, ≥2; floors are numbered 0..N_FLOORS-1.
- FW, 2: floor index width, must satisfy 2^FW ≥ N_FLOORS.
- TICK_DIV, 10: clock cycles per 100 ms tick; the board build uses CLK_FREQ/10.
- MOVE_T, 30: travel time per floor, in ticks; range 1..99.
- DOOR_T, 40: door-open time, in ticks; range 1..99.
- BEEP_T, 5: beeper active for the last BEEP_T ticks of the door phase; 0 disables it.

Ports:
- clk  in  1  system clock.
- sysclr_n  in  1  asynchronous, active-low reset.
- en  in  1  run enable. When 0, the FSM, prescaler and phase timer hold; request capture continues.
- call_req  in  N_FLOORS  per-floor call buttons, synchronous level; the rising edge registers a request.
- call_clr  in  1  synchronous clear of all pending requests.
- led  out  N_FLOORS  pending-request mask.
- floor_disp  out  FW  current floor.
- state_up / state_down / state_stay  out  1 each  one-hot car motion; state_stay covers IDLE and DOOR.
- door_open  out  1  high in DOOR.
- cnt_s_disp / cnt_ms_disp  out  4 each  BCD remaining time of the current phase (seconds / tenths).
- beep_en  out  1  door-closing warning.

Behaviour:
- Reset values:
  - FSM = IDLE, floor = 0, dir = up.
  - pending = 0, call_req edge history = 0.
  - prescaler = 0, timer = 0.
  - All outputs 0 except state_stay = 1.
- Tick and timer:
  - The prescaler counts 0..TICK_DIV-1 only in MOVE_UP, MOVE_DOWN and DOOR with en = 1. tick = (prescaler == TICK_DIV-1).
  - The phase timer increments on each tick. Prescaler and timer zero on every phase entry and in IDLE.
  - phase_done = tick && timer == LIMIT-1, where LIMIT = MOVE_T or DOOR_T.
- Request capture, per floor i, each cycle:
  - rise = call_req[i] && !prev[i].
  - If rise and the car is stopped at floor i (IDLE or DOOR), do not set pending; in DOOR, restart the timer instead (door reopen).
  - Otherwise, rise sets pending[i].
  - call_clr clears all pending bits and beats a simultaneous rise.
- Scheduler signals, combinational from pending and floor:
  - above = any pending above the current floor.
  - below = any pending below the current floor.
  - here = pending[floor].
- FSM (evaluated only when en = 1):
  - IDLE:
    - here → DOOR, clear pending[floor].
    - else if above && (dir == up || !below) → MOVE_UP, dir = up.
    - else if below → MOVE_DOWN, dir = down.
    - else stay in IDLE.
  - MOVE_UP: on phase_done, floor += 1.
    - If pending[floor+1] → DOOR and clear that bit.
    - Else if there is a request above floor+1 → re-enter MOVE_UP (timer restarts).
    - Else → IDLE.
  - MOVE_DOWN: mirror image of MOVE_UP.
  - DOOR: on phase_done → IDLE. The same-floor reopen rule above applies.
- Boundaries:
  - The car never moves above N_FLOORS-1 or below 0; above/below are false at the ends by construction.
  - A request cleared by call_clr mid-travel: the car completes the current floor step, then re-evaluates.
- Countdown display:
  - Remaining = LIMIT - timer, in ticks, shown as BCD seconds/tenths. Example: 30 → 3, 0.
  - IDLE shows 0, 0.
- beep_en = DOOR && (DOOR_T - timer) ≤ BEEP_T && BEEP_T ≠ 0.
- Reset mid-operation returns every register to its reset value immediately.
- Outputs are combinational from registered state, so there is zero added latency.
- A call registered in cycle k appears on led in cycle k+1.

Test Plan (defaults):
1. Reset, then pulse call_req[2] → led = 0100; MOVE_UP after 1 cycle; floor_disp 0→1 after 300 cycles, 1→2 after 600; DOOR at 600 with led = 0; IDLE 400 cycles later; beep_en high for the final 50 cycles of the door phase.
2. At floor 0, pend floors 3 and 1; while moving up, press call_req[0] → stops at 1 (door) and then 3 before returning to 0. Order 1, 3, 0 confirms SCAN.
3. Hold en = 0 for 100 cycles mid-MOVE_UP → floor, countdown and state frozen. Press call_req[3] during the hold → led bit 3 sets. Resume → timing continues from the frozen value.
4. In DOOR at floor 2 with 10 ticks left, pulse call_req[2] → timer restarts and countdown = 4, 0; pending[2] stays 0.
5. Press call_req[1] then assert call_clr in the same cycle as call_req[3] rises → led = 0; the car finishes the current step, then goes IDLE.
6. Assert sysclr_n low asynchronously mid-MOVE_DOWN → floor_disp = 0, led = 0, state_stay = 1, countdown 0, 0 before the next clk edge.

Source files
------------

// File: rtl/ele_ctrl_n.sv
// Multi-floor elevator controller: edge-captured per-floor calls, SCAN scheduling,
// prescaled travel/door phase timing and BCD countdown for the board display.
module ele_ctrl_n #(
  parameter int N_FLOORS = 4,
  parameter int FW       = 2,
  parameter int TICK_DIV = 10,
  parameter int MOVE_T   = 30,
  parameter int DOOR_T   = 40,
  parameter int BEEP_T   = 5
) (
  input  logic                clk,
  input  logic                sysclr_n,
  input  logic                en,
  input  logic [N_FLOORS-1:0] call_req,
  input  logic                call_clr,
  output logic [N_FLOORS-1:0] led,
  output logic [FW-1:0]       floor_disp,
  output logic                state_up,
  output logic                state_down,
  output logic                state_stay,
  output logic                door_open,
  output logic [3:0]          cnt_s_disp,
  output logic [3:0]          cnt_ms_disp,
  output logic                beep_en
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW = 7;

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;

  state_t              state, state_nxt;
  logic [FW-1:0]       floor_q, floor_nxt, floor_step;
  logic                dir_up, dir_up_nxt;
  logic [N_FLOORS-1:0] pending, pend_nxt, pend_clr, prev_req, rise, stop_mask;
  logic [PW-1:0]       presc;
  logic [TW-1:0]       timer, limit, remain;
  logic                running, tick, phase_done, restart, reopen;
  logic                above, below, here, beyond_up, beyond_dn;

  function automatic logic [3:0] bcd_tens(input logic [TW-1:0] v);
    bcd_tens = 4'(v / TW'(10));
  endfunction

  function automatic logic [3:0] bcd_ones(input logic [TW-1:0] v);
    bcd_ones = 4'(v % TW'(10));
  endfunction

  assign running    = en && (state != IDLE);
  assign tick       = running && (presc == PW'(TICK_DIV - 1));
  assign limit      = (state == DOOR) ? TW'(DOOR_T) : TW'(MOVE_T);
  assign phase_done = tick && (timer == limit - TW'(1));
  assign floor_step = (state == MOVE_DOWN) ? floor_q - FW'(1) : floor_q + FW'(1);
  assign here       = pending[floor_q];

  // Scheduler view of pending requests relative to the car
  always_comb begin
    above     = 1'b0;
    below     = 1'b0;
    beyond_up = 1'b0;
    beyond_dn = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (pending[i]) begin
        if (i > int'(floor_q))     above     = 1'b1;
        if (i < int'(floor_q))     below     = 1'b1;
        if (i > int'(floor_q) + 1) beyond_up = 1'b1;
        if (i + 1 < int'(floor_q)) beyond_dn = 1'b1;
      end
    end
  end

  // A press at the floor where the car stands is absorbed (reopens the door if open)
  always_comb begin
    rise      = call_req & ~prev_req;
    stop_mask = '0;
    if (state == IDLE || state == DOOR) stop_mask[floor_q] = 1'b1;
    reopen    = (state == DOOR) && |(rise & stop_mask);
  end

  always_comb begin
    state_nxt  = state;
    floor_nxt  = floor_q;
    dir_up_nxt = dir_up;
    pend_clr   = '0;
    restart    = 1'b0;
    if (en) begin
      case (state)
        IDLE: begin
          if (here) begin
            state_nxt         = DOOR;
            pend_clr[floor_q] = 1'b1;
            restart           = 1'b1;
          end else if (above && (dir_up || !below)) begin
            state_nxt  = MOVE_UP;
            dir_up_nxt = 1'b1;
            restart    = 1'b1;
          end else if (below) begin
            state_nxt  = MOVE_DOWN;
            dir_up_nxt = 1'b0;
            restart    = 1'b1;
          end
        end
        MOVE_UP, MOVE_DOWN: begin
          if (phase_done) begin
            floor_nxt = floor_step;
            restart   = 1'b1;
            if (pending[floor_step]) begin
              state_nxt            = DOOR;
              pend_clr[floor_step] = 1'b1;
            end else if (!((state == MOVE_UP) ? beyond_up : beyond_dn)) begin
              state_nxt = IDLE;
            end
          end
        end
        DOOR: begin
          if (phase_done) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
    if (reopen) begin
      state_nxt = DOOR;
      restart   = 1'b1;
    end
  end

  always_comb begin
    pend_nxt = (pending | (rise & ~stop_mask)) & ~pend_clr;
    if (call_clr) pend_nxt = '0;
  end

  always_ff @(posedge clk or negedge sysclr_n) begin
    if (!sysclr_n) begin
      state    <= IDLE;
      floor_q  <= '0;
      dir_up   <= 1'b1;
      pending  <= '0;
      prev_req <= '0;
      presc    <= '0;
      timer    <= '0;
    end else begin
      state    <= state_nxt;
      floor_q  <= floor_nxt;
      dir_up   <= dir_up_nxt;
      pending  <= pend_nxt;
      prev_req <= call_req;
      if (restart || state_nxt == IDLE) begin
        presc <= '0;
        timer <= '0;
      end else if (running) begin
        if (tick) begin
          presc <= '0;
          timer <= timer + TW'(1);
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

  assign remain      = (state == IDLE) ? '0 : limit - timer;
  assign led         = pending;
  assign floor_disp  = floor_q;
  assign state_up    = (state == MOVE_UP);
  assign state_down  = (state == MOVE_DOWN);
  assign state_stay  = (state == IDLE) || (state == DOOR);
  assign door_open   = (state == DOOR);
  assign cnt_s_disp  = bcd_tens(remain);
  assign cnt_ms_disp = bcd_ones(remain);
  assign beep_en     = (state == DOOR) && (BEEP_T != 0) &&
                       ((TW'(DOOR_T) - timer) <= TW'(BEEP_T));

endmodule

// File: tb/tb_ele_ctrl_n.sv
// Bench for ele_ctrl_n: hand-computed vector table, scenario sequences and a
// cycle-level behavioural model checked on every clock.
module tb_ele_ctrl_n;
  localparam int N = 4, FW = 2, TD = 10, MT = 30, DT = 40, BT = 5;
  localparam int MI = 0, MU = 1, MD = 2, MO = 3;

  logic          clk = 1'b0;
  logic          sysclr_n, en, call_clr;
  logic [N-1:0]  call_req, led;
  logic [FW-1:0] floor_disp;
  logic          state_up, state_down, state_stay, door_open, beep_en;
  logic [3:0]    cnt_s_disp, cnt_ms_disp;

  always #5 clk = ~clk;

  ele_ctrl_n #(.N_FLOORS(N), .FW(FW), .TICK_DIV(TD), .MOVE_T(MT), .DOOR_T(DT), .BEEP_T(BT)) dut (
    .clk(clk), .sysclr_n(sysclr_n), .en(en), .call_req(call_req), .call_clr(call_clr),
    .led(led), .floor_disp(floor_disp), .state_up(state_up), .state_down(state_down),
    .state_stay(state_stay), .door_open(door_open), .cnt_s_disp(cnt_s_disp),
    .cnt_ms_disp(cnt_ms_disp), .beep_en(beep_en));

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: phase progress kept as elapsed enabled cycles
  int           m_mode, m_floor, m_el;
  bit           m_up;
  logic [N-1:0] m_pend, m_prev;

  task automatic model_reset();
    m_mode = MI; m_floor = 0; m_el = 0; m_up = 1'b1; m_pend = '0; m_prev = '0;
  endtask

  function automatic bit any_in(input logic [N-1:0] p, input int lo, input int hi);
    for (int i = lo; i <= hi; i++)
      if (i >= 0 && i < N && p[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step(input logic e, input logic [N-1:0] r, input logic c);
    logic [N-1:0] np, rs;
    bit reopen;
    int nf;
    rs = r & ~m_prev;
    m_prev = r;
    np = m_pend;
    reopen = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (rs[i]) begin
        if ((m_mode == MI || m_mode == MO) && m_floor == i) begin
          if (m_mode == MO) reopen = 1'b1;
        end else np[i] = 1'b1;
      end
    end
    if (e) begin
      case (m_mode)
        MI: begin
          m_el = 0;
          if (m_pend[m_floor]) begin
            m_mode = MO; np[m_floor] = 1'b0;
          end else if (any_in(m_pend, m_floor + 1, N - 1) &&
                       (m_up || !any_in(m_pend, 0, m_floor - 1))) begin
            m_mode = MU; m_up = 1'b1;
          end else if (any_in(m_pend, 0, m_floor - 1)) begin
            m_mode = MD; m_up = 1'b0;
          end
        end
        MU, MD: begin
          if (m_el == MT * TD - 1) begin
            nf = (m_mode == MU) ? m_floor + 1 : m_floor - 1;
            m_el = 0;
            if (m_pend[nf]) begin
              m_mode = MO; np[nf] = 1'b0;
            end else if (!((m_mode == MU) ? any_in(m_pend, nf + 1, N - 1)
                                           : any_in(m_pend, 0, nf - 1))) begin
              m_mode = MI;
            end
            m_floor = nf;
          end else m_el++;
        end
        default: begin
          if (m_el == DT * TD - 1) begin
            m_mode = MI; m_el = 0;
          end else m_el++;
        end
      endcase
    end
    if (reopen) begin
      m_mode = MO; m_el = 0;
    end
    if (c) np = '0;
    m_pend = np;
  endtask

  function automatic logic [18:0] model_out();
    int lim, rem, left;
    lim  = (m_mode == MO) ? DT : MT;
    rem  = (m_mode == MI) ? 0 : lim - m_el / TD;
    left = DT - m_el / TD;
    return {m_pend, FW'(m_floor), m_mode == MU, m_mode == MD, (m_mode == MI || m_mode == MO),
            m_mode == MO, 4'(rem / 10), 4'(rem % 10), (m_mode == MO && left <= BT && BT != 0)};
  endfunction

  function automatic logic [18:0] dut_out();
    return {led, floor_disp, state_up, state_down, state_stay, door_open,
            cnt_s_disp, cnt_ms_disp, beep_en};
  endfunction

  task automatic step();
    @(posedge clk);
    if (sysclr_n) model_step(en, call_req, call_clr);
    #1;
    chk("model", 32'(dut_out()), 32'(model_out()));
  endtask

  // Asynchronous reset pulse away from the clock edge; outputs checked before the next edge
  task automatic do_reset(input string tag);
    #3;
    sysclr_n = 1'b0;
    en = 1'b1; call_req = '0; call_clr = 1'b0;
    #2;
    chk({tag, "_led"},   32'(led), 32'(0));
    chk({tag, "_floor"}, 32'(floor_disp), 32'(0));
    chk({tag, "_state"}, 32'({state_up, state_down, state_stay, door_open}), 32'(4'b0010));
    chk({tag, "_cnt"},   32'({cnt_s_disp, cnt_ms_disp}), 32'(0));
    chk({tag, "_beep"},  32'(beep_en), 32'(0));
    sysclr_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic en; logic [N-1:0] req; logic clr; int cyc;
    logic [N-1:0] led; logic [FW-1:0] flr; logic [2:0] st; logic door;
    logic [3:0] cs; logic [3:0] cms; logic beep;
  } vec_t;
  vec_t vt[13];

  initial begin
    int cnt, o0, o1, o2, nd;
    logic pd;
    vt[0]  = '{1'b1, 4'b0100, 1'b0,   1, 4'b0100, 2'd0, 3'b001, 1'b0, 4'd0, 4'd0, 1'b0};
    vt[1]  = '{1'b1, 4'b0000, 1'b0,   1, 4'b0100, 2'd0, 3'b100, 1'b0, 4'd3, 4'd0, 1'b0};
    vt[2]  = '{1'b1, 4'b0000, 1'b0, 299, 4'b0100, 2'd0, 3'b100, 1'b0, 4'd0, 4'd1, 1'b0};
    vt[3]  = '{1'b1, 4'b0000, 1'b0,   1, 4'b0100, 2'd1, 3'b100, 1'b0, 4'd3, 4'd0, 1'b0};
    vt[4]  = '{1'b1, 4'b0000, 1'b0, 300, 4'b0000, 2'd2, 3'b001, 1'b1, 4'd4, 4'd0, 1'b0};
    vt[5]  = '{1'b1, 4'b0000, 1'b0, 300, 4'b0000, 2'd2, 3'b001, 1'b1, 4'd1, 4'd0, 1'b0};
    vt[6]  = '{1'b1, 4'b0100, 1'b0,   1, 4'b0000, 2'd2, 3'b001, 1'b1, 4'd4, 4'd0, 1'b0};
    vt[7]  = '{1'b1, 4'b0000, 1'b0, 349, 4'b0000, 2'd2, 3'b001, 1'b1, 4'd0, 4'd6, 1'b0};
    vt[8]  = '{1'b1, 4'b0000, 1'b0,   1, 4'b0000, 2'd2, 3'b001, 1'b1, 4'd0, 4'd5, 1'b1};
    vt[9]  = '{1'b1, 4'b0000, 1'b0,  49, 4'b0000, 2'd2, 3'b001, 1'b1, 4'd0, 4'd1, 1'b1};
    vt[10] = '{1'b1, 4'b0000, 1'b0,   1, 4'b0000, 2'd2, 3'b001, 1'b0, 4'd0, 4'd0, 1'b0};
    vt[11] = '{1'b1, 4'b0001, 1'b0,   1, 4'b0001, 2'd2, 3'b001, 1'b0, 4'd0, 4'd0, 1'b0};
    vt[12] = '{1'b1, 4'b0000, 1'b0,   1, 4'b0001, 2'd2, 3'b010, 1'b0, 4'd3, 4'd0, 1'b0};

    sysclr_n = 1'b0; en = 1'b1; call_req = '0; call_clr = 1'b0;
    model_reset();
    #12;
    chk("rst_led",   32'(led), 32'(0));
    chk("rst_floor", 32'(floor_disp), 32'(0));
    chk("rst_state", 32'({state_up, state_down, state_stay, door_open}), 32'(4'b0010));
    chk("rst_cnt",   32'({cnt_s_disp, cnt_ms_disp}), 32'(0));
    chk("rst_beep",  32'(beep_en), 32'(0));
    sysclr_n = 1'b1;

    // Single call to floor 2, door reopen with 10 ticks left, then a call down to 0
    for (int k = 0; k < 13; k++) begin
      en = vt[k].en; call_req = vt[k].req; call_clr = vt[k].clr;
      repeat (vt[k].cyc) step();
      chk($sformatf("vec%0d_led", k),   32'(led), 32'(vt[k].led));
      chk($sformatf("vec%0d_floor", k), 32'(floor_disp), 32'(vt[k].flr));
      chk($sformatf("vec%0d_state", k), 32'({state_up, state_down, state_stay}), 32'(vt[k].st));
      chk($sformatf("vec%0d_door", k),  32'(door_open), 32'(vt[k].door));
      chk($sformatf("vec%0d_cnt", k),   32'({cnt_s_disp, cnt_ms_disp}), 32'({vt[k].cs, vt[k].cms}));
      chk($sformatf("vec%0d_beep", k),  32'(beep_en), 32'(vt[k].beep));
    end

    // Reset mid-MOVE_DOWN
    repeat (150) step();
    chk("t6_pre_down", 32'(state_down), 32'(1));
    do_reset("t6");

    // Run-enable hold mid-travel with a call captured during the hold
    call_req = 4'b0010; step();
    call_req = 4'b0000; step();
    repeat (100) step();
    chk("t3_cnt_before", 32'({cnt_s_disp, cnt_ms_disp}), 32'(8'h20));
    en = 1'b0;
    repeat (50) step();
    call_req = 4'b1000; step();
    call_req = 4'b0000;
    repeat (49) step();
    chk("t3_hold_led",   32'(led), 32'(4'b1010));
    chk("t3_hold_floor", 32'(floor_disp), 32'(0));
    chk("t3_hold_up",    32'(state_up), 32'(1));
    chk("t3_hold_cnt",   32'({cnt_s_disp, cnt_ms_disp}), 32'(8'h20));
    en = 1'b1;
    repeat (199) step();
    chk("t3_resume_floor", 32'(floor_disp), 32'(0));
    chk("t3_resume_cnt",   32'({cnt_s_disp, cnt_ms_disp}), 32'(8'h01));
    step();
    chk("t3_arrive_floor", 32'(floor_disp), 32'(1));
    chk("t3_arrive_door",  32'(door_open), 32'(1));
    chk("t3_arrive_led",   32'(led), 32'(4'b1000));
    do_reset("t3");

    // Clear of all requests mid-travel: car finishes its step then idles
    call_req = 4'b0010; step();
    call_req = 4'b0000; step();
    repeat (20) step();
    call_req = 4'b1000; call_clr = 1'b1; step();
    chk("t5_clr_led", 32'(led), 32'(0));
    call_req = 4'b0000; call_clr = 1'b0;
    cnt = 0;
    while (!state_stay && cnt < 1000) begin
      step();
      cnt++;
    end
    chk("t5_cycles", 32'(cnt), 32'(279));
    chk("t5_floor",  32'(floor_disp), 32'(1));
    chk("t5_door",   32'(door_open), 32'(0));
    chk("t5_led",    32'(led), 32'(0));
    do_reset("t5");

    // SCAN order: pending 3 and 1, then 0 pressed while moving up
    call_req = 4'b1010; step();
    call_req = 4'b0000; step();
    call_req = 4'b0001; step();
    call_req = 4'b0000;
    o0 = 99; o1 = 99; o2 = 99; nd = 0; pd = 1'b0; cnt = 0;
    while (nd < 3 && cnt < 6000) begin
      step();
      cnt++;
      if (door_open && !pd) begin
        if (nd == 0) o0 = int'(floor_disp);
        else if (nd == 1) o1 = int'(floor_disp);
        else o2 = int'(floor_disp);
        nd++;
      end
      pd = door_open;
    end
    chk("t2_doors", 32'(nd), 32'(3));
    chk("t2_first", 32'(o0), 32'(1));
    chk("t2_second", 32'(o1), 32'(3));
    chk("t2_third", 32'(o2), 32'(0));
    do_reset("t2");

    // Randomized traffic against the model
    for (int i = 0; i < 8000; i++) begin
      if (i == 4000) do_reset("rnd");
      for (int b = 0; b < N; b++) call_req[b] = ($urandom_range(0, 149) == 0);
      en       = ($urandom_range(0, 19) != 0);
      call_clr = ($urandom_range(0, 999) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
